adder_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one registered signed adder (1-cycle latency, C = A + B, WIDTH+1 bit result) among NUM_REQ requesters. It accepts one operand pair at a time through a per-requester valid/ready handshake and drives the adder's A/B inputs. It captures the adder's C output and returns the sum with the requester ID on a single valid/ready response channel. It sits between the requesting blocks and the adder instance.

---
 rtl/adder_rr_scheduler.sv | 113 +++++++++++
 tb/tb_adder_rr_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin front end for one registered signed adder: grants one requester at a time,
// drives the adder operands and returns the sum tagged with the requester ID.
module adder_rr_scheduler #(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   input  logic [WIDTH:0]           add_c,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH:0]           rsp_data,
   output logic                     busy,
   output logic [1:0]               dbg_state
);

   // Handshakes: a request transfers at a rising edge where req_valid[i] && req_ready[i];
   // a response transfers at a rising edge where rsp_valid && rsp_ready. Once raised,
   // rsp_valid/rsp_id/rsp_data stay stable until that transfer.

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   last_grant, gnt_id, grant_idx, scan_idx;
   logic              grant_found;
   logic [WIDTH-1:0]  a_arr [NUM_REQ];
   logic [WIDTH-1:0]  b_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
      assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
   end

   // Scan from farthest to nearest so the requester closest after last_grant wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan_idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
         if (req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_found) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (reset && state == IDLE && grant_found)
         req_ready = NUM_REQ'(1) << grant_idx;
      busy      = (state != IDLE);
      dbg_state = state;
   end

   // Operand registers are only reloaded on a grant, so they hold their last values otherwise.
   always_ff @(posedge clk) begin
      if (!reset) begin
         add_a      <= '0;
         add_b      <= '0;
         gnt_id     <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  add_a      <= a_arr[grant_idx];
                  add_b      <= b_arr[grant_idx];
                  gnt_id     <= grant_idx;
                  last_grant <= grant_idx;
               end
            end
            WAIT: begin
               rsp_data  <= add_c;
               rsp_id    <= gnt_id;
               rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: per-requester operand tables feed a driver, grants push
// expected {id,sum} into a queue, and a monitor pops and compares on each response.
module tb_adder_rr_scheduler;
   localparam int NR  = 4;
   localparam int W   = 4;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NR-1:0]     req_valid, req_ready;
   logic [NR*W-1:0]   req_a, req_b;
   logic [W-1:0]      add_a, add_b;
   logic [W:0]        add_c = '0;
   logic              rsp_valid, rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W:0]        rsp_data;
   logic              busy;
   logic [1:0]        dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [W-1:0]   ta [NR][128];
   logic [W-1:0]   tb_ [NR][128];
   logic [W:0]     ts [NR][128];
   int             cnt [NR] = '{default: 0};
   int             head [NR] = '{default: 0};
   int             gap [NR] = '{default: 0};
   int             wcnt [NR] = '{default: 0};
   bit             rand_mode = 1'b0;
   logic [NR-1:0]  hs_last = '0;

   logic [IDW+W:0] exp_q[$];
   int             got_id_q[$];
   int             got_cyc_q[$];

   adder_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .add_a(add_a), .add_b(add_b), .add_c(add_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy), .dbg_state(dbg_state)
   );

   // clock and the registered adder the scheduler is meant to drive
   always #5 clk = ~clk;
   always @(posedge clk) add_c <= {add_a[W-1], add_a} + {add_b[W-1], add_b};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic load(input int i, input int a, input int b, input int s);
      ta[i][cnt[i]]  = W'(a);
      tb_[i][cnt[i]] = W'(b);
      ts[i][cnt[i]]  = (W+1)'(s);
      cnt[i]++;
   endtask

   task automatic wait_grant(input string name, input int budget);
      bit seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         seen = (req_ready != '0);
      end
      chk(name, seen, 1);
   endtask

   task automatic wait_rsp(input string name, input int budget);
      bit seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      chk(name, seen, 1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !busy && (req_valid == '0);
         for (int i = 0; i < NR; i++) if (head[i] != cnt[i]) done = 1'b0;
      end
      chk(name, done, 1);
   endtask

   // driver: each requester presents its table entries in order and holds valid until granted
   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (hs_last[i]) begin
               head[i]++;
               gap[i] = rand_mode ? int'($urandom_range(0, 3)) : 0;
            end else if (gap[i] > 0 && !req_valid[i]) begin
               gap[i]--;
            end
            if (head[i] < cnt[i] && gap[i] == 0) begin
               req_valid[i]     = 1'b1;
               req_a[i*W +: W]  = ta[i][head[i]];
               req_b[i*W +: W]  = tb_[i][head[i]];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
         hs_last = '0;
         if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // monitor: grant bookkeeping, invariants, response scoreboard
   always @(negedge clk) begin : mon
      logic [NR-1:0]  hs;
      logic [IDW+W:0] e;
      cyc++;
      hs = req_valid & req_ready;
      chk("req_ready_onehot0", $onehot0(req_ready), 1);
      chk("req_ready_without_valid", (req_ready & ~req_valid) == '0, 1);
      if (!reset) begin
         chk("req_ready_in_reset", req_ready, 0);
         for (int i = 0; i < NR; i++) wcnt[i] = 0;
      end
      if (hs != '0) begin
         for (int j = 0; j < NR; j++) begin
            if (hs[j]) begin
               exp_q.push_back({IDW'(j), ts[j][head[j]]});
               wcnt[j] = 0;
            end else if (req_valid[j]) begin
               wcnt[j]++;
               if (wcnt[j] > 3) chk("fairness_wait", wcnt[j], 3);
            end
         end
         hs_last = hs;
      end
      if (reset && rsp_valid && rsp_ready) begin
         got_id_q.push_back(int'(rsp_id));
         got_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", rsp_id, e[IDW+W:W+1]);
            chk("rsp_data", rsp_data, e[W:0]);
         end
      end
   end

   int exp_order [5] = '{0, 1, 2, 3, 0};

   initial begin
      // reset hold with all four requesters valid, then round-robin order 0,1,2,3,0
      load(0, -8, -8, -16);
      load(0, -8, -8, -16);
      load(1, 7, -8, -1);
      load(2, -1, 1, 0);
      load(3, 3, 4, 7);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid_applied", req_valid, 4'b1111);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_rsp_data", rsp_data, 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      got_id_q.delete();
      got_cyc_q.delete();
      wait_grant("t1_grant_timeout", 10);
      chk("t1_first_grant", req_ready, 4'b0001);
      wait_idle("t1_drain_timeout", 60);
      chk("t3_rsp_count", got_id_q.size(), 5);
      if (got_id_q.size() == 5) begin
         for (int k = 0; k < 5; k++) chk("t3_grant_order", got_id_q[k], exp_order[k]);
         for (int k = 1; k < 5; k++) chk("t3_rsp_spacing", got_cyc_q[k] - got_cyc_q[k-1], 4);
      end

      // single requester 1: latency and result 7+7
      load(1, 7, 7, 14);
      wait_grant("t2_grant_timeout", 10);
      chk("t2_grant", req_ready, 4'b0010);
      @(negedge clk);
      chk("t2_busy_t1", busy, 1);
      chk("t2_rsp_valid_t1", rsp_valid, 0);
      @(negedge clk);
      chk("t2_rsp_valid_t2", rsp_valid, 0);
      @(negedge clk);
      chk("t2_rsp_valid_t3", rsp_valid, 1);
      chk("t2_rsp_id_t3", rsp_id, 1);
      chk("t2_rsp_data_t3", rsp_data, 5'b01110);
      @(negedge clk);
      chk("t2_busy_t4", busy, 0);
      wait_idle("t2_drain_timeout", 20);

      // backpressure: response 5+6 held while another requester waits
      rsp_ready = 1'b0;
      load(0, 5, 6, 11);
      wait_rsp("t4_rsp_timeout", 10);
      load(1, 1, 2, 3);
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("t4_hold_valid", rsp_valid, 1);
         chk("t4_hold_id", rsp_id, 0);
         chk("t4_hold_data", rsp_data, 11);
         chk("t4_hold_req_ready", req_ready, 0);
      end
      @(posedge clk);
      #2;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t4_next_grant", req_ready, 4'b0010);
      wait_idle("t4_drain_timeout", 20);

      // reset during WAIT discards the transaction and restarts the pointer
      load(2, 3, 3, 6);
      wait_grant("t5_grant_timeout", 10);
      chk("t5_grant", req_ready, 4'b0100);
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      chk("t5_in_wait", dbg_state, 2);
      reset = 1'b0;
      exp_q.delete();
      load(2, 1, 1, 2);
      load(0, 2, 2, 4);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("t5_no_rsp", rsp_valid, 0);
      end
      chk("t5_busy_after_reset", busy, 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      wait_grant("t5_regrant_timeout", 10);
      chk("t5_pointer_reset", req_ready, 4'b0001);
      wait_idle("t5_drain_timeout", 30);

      // random operands, request gaps and response backpressure
      for (int n = 0; n < 200; n++) begin
         int i, a, b, sa, sb;
         i  = int'($urandom_range(0, NR - 1));
         a  = int'($urandom_range(0, 15));
         b  = int'($urandom_range(0, 15));
         sa = (a >= 8) ? a - 16 : a;
         sb = (b >= 8) ? b - 16 : b;
         load(i, a, b, sa + sb);
      end
      rand_mode = 1'b1;
      wait_idle("t6_drain_timeout", 8000);
      rand_mode = 1'b0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
